// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// A shadow pipe tracks every in-flight writer from EX onward, so the
// datapath never has to route per-stage destination/write-back buses here.
// Outputs are a forward select per EX-stage operand and a load-use stall
// for the ID-stage instruction.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic                      id_wb,
    input  logic                      id_is_load,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [15:0]               stall_count
);

    // Shadow entries: index 0 is the EX stage, higher indices are older.
    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0]          wb_q, wb_d;
    logic [DEPTH-1:0]          load_q, load_d;
    logic [REG_AW-1:0]         dst_q [DEPTH];
    logic [REG_AW-1:0]         dst_d [DEPTH];
    // Source operands of the instruction currently in EX.
    logic [NUM_SRC*REG_AW-1:0] ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]        ex_used_q, ex_used_d;
    logic [15:0]               stall_count_q, stall_count_d;

    // Flattened match matrices, bit [i*DEPTH + k]: operand i vs stage k.
    logic [NUM_SRC*DEPTH-1:0]  ex_match;
    logic [NUM_SRC*DEPTH-1:0]  id_match;
    // Youngest forwarding source would be a load whose data is not ready yet.
    logic                      load_early;

    // Writer at stage k matches a register when it is a live, writing
    // instruction with that destination; r0 never matches anything.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            for (genvar gk = 0; gk < DEPTH; gk++) begin : g_stage
                assign ex_match[gi*DEPTH + gk] =
                    valid_q[gk] && wb_q[gk] &&
                    (dst_q[gk] == ex_src_q[gi*REG_AW +: REG_AW]) &&
                    (ex_src_q[gi*REG_AW +: REG_AW] != '0);
                assign id_match[gi*DEPTH + gk] =
                    valid_q[gk] && wb_q[gk] &&
                    (dst_q[gk] == id_src[gi*REG_AW +: REG_AW]) &&
                    (id_src[gi*REG_AW +: REG_AW] != '0);
            end
        end
    endgenerate

    // Forward select per EX operand: the youngest matching older stage wins.
    always_comb begin
        fwd_sel    = '0;
        load_early = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic early_i;
            early_i = 1'b0;
            // Walk oldest to youngest so the last hit is the youngest one.
            for (int k = DEPTH-1; k >= 1; k--) begin
                if (ex_used_q[i] && ex_match[i*DEPTH + k]) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    early_i = load_q[k] && (k <= LOAD_LAT);
                end
            end
            load_early = load_early | early_i;
        end
    end

    // Load-use stall: a used ID operand depends on a load whose data is
    // still inside the first LOAD_LAT shadow stages.
    always_comb begin
        stall = 1'b0;
        if (id_valid && !flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int k = 0; k < LOAD_LAT; k++) begin
                    if (id_src_used[i] && load_q[k] && id_match[i*DEPTH + k]) begin
                        stall = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state: shift the shadow pipe unless frozen; insert ID or a bubble.
    always_comb begin
        valid_d       = valid_q;
        wb_d          = wb_q;
        load_d        = load_q;
        dst_d         = dst_q;
        ex_src_d      = ex_src_q;
        ex_used_d     = ex_used_q;
        stall_count_d = stall_count_q;
        if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                wb_d[k]    = wb_q[k-1];
                load_d[k]  = load_q[k-1];
                dst_d[k]   = dst_q[k-1];
            end
            // A taken branch kills the instruction leaving EX as well.
            if (flush) begin
                valid_d[1] = 1'b0;
            end
            if (id_valid && !stall && !flush) begin
                valid_d[0] = 1'b1;
                wb_d[0]    = id_wb;
                load_d[0]  = id_is_load;
                dst_d[0]   = id_dst;
                ex_src_d   = id_src;
                ex_used_d  = id_src_used;
            end else begin
                valid_d[0] = 1'b0;
                wb_d[0]    = 1'b0;
                load_d[0]  = 1'b0;
                dst_d[0]   = '0;
                ex_src_d   = '0;
                ex_used_d  = '0;
            end
            if (stall && (stall_count_q != 16'hFFFF)) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    // State registers; reset drops every tracked writer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            wb_q          <= '0;
            load_q        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= '0;
            end
            ex_src_q      <= '0;
            ex_used_q     <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            wb_q          <= wb_d;
            load_q        <= load_d;
            dst_q         <= dst_d;
            ex_src_q      <= ex_src_d;
            ex_used_q     <= ex_used_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

    // The stall must have kept any consumer away from a not-yet-ready load.
    assert property (@(posedge clk) disable iff (rst) !load_early);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: instance A uses DEPTH=3/LOAD_LAT=1,
// instance B uses DEPTH=4/LOAD_LAT=2. Expectations are queued as stimulus
// is applied and popped/compared once the outputs have settled.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;

    logic        id_valid_a, id_wb_a, id_load_a, stall_a;
    logic [9:0]  id_src_a;
    logic [1:0]  id_used_a;
    logic [4:0]  id_dst_a;
    logic [3:0]  fwd_a;
    logic [15:0] cnt_a;

    logic        id_valid_b, id_wb_b, id_load_b, stall_b;
    logic [9:0]  id_src_b;
    logic [1:0]  id_used_b;
    logic [4:0]  id_dst_b;
    logic [3:0]  fwd_b;
    logic [15:0] cnt_b;

    int n_err;
    int n_checks;

    string       tag_q[$];
    int          kind_q[$];
    logic [15:0] exp_q[$];

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid_a), .id_src(id_src_a), .id_src_used(id_used_a),
        .id_dst(id_dst_a), .id_wb(id_wb_a), .id_is_load(id_load_a),
        .stall(stall_a), .fwd_sel(fwd_a), .stall_count(cnt_a)
    );

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .DEPTH(4), .LOAD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid_b), .id_src(id_src_b), .id_src_used(id_used_b),
        .id_dst(id_dst_b), .id_wb(id_wb_b), .id_is_load(id_load_b),
        .stall(stall_b), .fwd_sel(fwd_b), .stall_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_a(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst,
                         input logic wb, input logic ld);
        id_valid_a = v; id_src_a = {s1, s0}; id_used_a = used;
        id_dst_a = dst; id_wb_a = wb; id_load_a = ld;
    endtask

    task automatic set_b(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst,
                         input logic wb, input logic ld);
        id_valid_b = v; id_src_b = {s1, s0}; id_used_b = used;
        id_dst_b = dst; id_wb_b = wb; id_load_b = ld;
    endtask

    task automatic idle_a();
        set_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic idle_b();
        set_b(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [15:0] v);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        exp_q.push_back(v);
    endtask

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            0:       return {15'd0, stall_a};
            1:       return {12'd0, fwd_a};
            2:       return cnt_a;
            3:       return {15'd0, stall_b};
            4:       return {12'd0, fwd_b};
            default: return cnt_b;
        endcase
    endfunction

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic chk();
        string       t;
        int          k;
        logic [15:0] e;
        logic [15:0] o;
        #1;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            o = observe(k);
            n_checks++;
            assert (o === e) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", t, o, e);
            end
            $display("check %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_err = 0;
        n_checks = 0;
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        idle_a(); idle_b();
        #2;
        expect_val("rst_stall", 0, 16'd0);
        expect_val("rst_sel", 1, 16'd0);
        expect_val("rst_cnt", 2, 16'd0);
        chk();
        cyc(); rst = 1'b0; cyc();

        // ALU producer directly ahead of its consumer
        set_a(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0);
        expect_val("t1_add_stall", 0, 16'd0); chk(); cyc();
        set_a(1, 5'd3, 5'd2, 2'b11, 5'd4, 1, 0);
        expect_val("t1_sub_stall", 0, 16'd0); chk(); cyc();
        idle_a();
        expect_val("t1_sel", 1, 16'h1); expect_val("t1_stall", 0, 16'd0); chk(); cyc();
        expect_val("t1_bubble_sel", 1, 16'd0); chk();

        // two writers of r3: the younger one must win on both operands
        set_a(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0); cyc();
        set_a(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0); cyc();
        set_a(1, 5'd3, 5'd3, 2'b11, 5'd5, 1, 0);
        expect_val("t2_stall", 0, 16'd0); chk(); cyc();
        idle_a();
        expect_val("t2_sel", 1, 16'h5); chk(); cyc(); cyc();

        // load-use with one cycle of load latency
        set_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1); cyc();
        set_a(1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0);
        expect_val("t3_stall1", 0, 16'd1); expect_val("t3_cnt0", 2, 16'd0); chk(); cyc();
        expect_val("t3_stall2", 0, 16'd0); expect_val("t3_cnt1", 2, 16'd1); chk(); cyc();
        idle_a();
        expect_val("t3_sel", 1, 16'h2); expect_val("t3_cnt", 2, 16'd1); chk(); cyc(); cyc();

        // r0 is never forwarded; flush drops the load leaving EX
        set_a(1, 5'd1, 5'd2, 2'b11, 5'd0, 1, 0); cyc();
        set_a(1, 5'd0, 5'd0, 2'b11, 5'd7, 1, 0);
        expect_val("t5_r0_stall", 0, 16'd0); chk(); cyc();
        set_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1);
        expect_val("t5_r0_sel", 1, 16'd0); chk(); cyc();
        set_a(1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0); flush = 1'b1;
        expect_val("t5_flush_stall", 0, 16'd0); chk(); cyc();
        flush = 1'b0;
        expect_val("t5_post_stall", 0, 16'd0); expect_val("t5_cnt", 2, 16'd1); chk(); cyc();
        idle_a();
        expect_val("t5_flush_sel", 1, 16'd0); chk(); cyc();
        set_a(1, 5'd1, 5'd0, 2'b01, 5'd0, 1, 1); cyc();
        set_a(1, 5'd0, 5'd0, 2'b11, 5'd8, 1, 0);
        expect_val("t5_lw_r0_stall", 0, 16'd0); chk(); cyc();
        idle_a(); cyc(); cyc();

        // hold freezes a load-use stall; hold overrides flush
        set_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1); cyc();
        set_a(1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0); hold = 1'b1;
        expect_val("t6_stall_h0", 0, 16'd1); chk();
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_val("t6_hold_stall", 0, 16'd1); expect_val("t6_hold_cnt", 2, 16'd1); chk();
        end
        hold = 1'b0; cyc();
        expect_val("t6_after_stall", 0, 16'd0); expect_val("t6_after_cnt", 2, 16'd2); chk();
        hold = 1'b1; flush = 1'b1;
        expect_val("t6_hf_stall", 0, 16'd0); chk(); cyc();
        hold = 1'b0; flush = 1'b0;
        expect_val("t6_hf_post_stall", 0, 16'd0); chk(); cyc();
        idle_a();
        expect_val("t6_hf_sel", 1, 16'h2); expect_val("t6_hf_cnt", 2, 16'd2); chk(); cyc();

        // asynchronous reset in the middle of a stall
        set_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1); cyc();
        set_a(1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0);
        expect_val("t6_pre_rst_stall", 0, 16'd1); expect_val("t6_pre_rst_cnt", 2, 16'd2); chk();
        rst = 1'b1; #1;
        expect_val("t6_rst_stall", 0, 16'd0); expect_val("t6_rst_cnt", 2, 16'd0);
        expect_val("t6_rst_sel", 1, 16'd0); chk();
        cyc(); rst = 1'b0;
        expect_val("t6_post_rst_stall", 0, 16'd0); chk(); cyc();
        idle_a();

        // two cycles of load latency on the deeper instance
        set_b(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1); cyc();
        set_b(1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0);
        expect_val("t4_stall1", 3, 16'd1); chk(); cyc();
        expect_val("t4_stall2", 3, 16'd1); expect_val("t4_cnt1", 5, 16'd1); chk(); cyc();
        expect_val("t4_stall3", 3, 16'd0); expect_val("t4_cnt2", 5, 16'd2); chk(); cyc();
        idle_b();
        expect_val("t4_sel", 4, 16'hF); expect_val("t4_cnt", 5, 16'd2); chk(); cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
